// File: rtl/port_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : port_xfer_ctrl
// Description : Per-input-port packet sequencer. Latches a header, holds a
//               one-hot request to the switch arbiter for the whole packet,
//               gates payload beats with grant, and drops empty/timed-out packets.
// Revision    : 1.0 - initial release
// ============================================================================
module port_xfer_ctrl #(
    parameter int DST_SIZE = 4,
    parameter int LEN_W    = 8,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hdr_valid,
    input  logic [DST_SIZE-1:0] hdr_dst,
    input  logic [LEN_W-1:0]    hdr_len,
    output logic                hdr_ready,
    input  logic                pl_valid,
    output logic                pl_ready,
    output logic [DST_SIZE-1:0] req_dst,
    input  logic                grant,
    output logic                xfer_valid,
    output logic                busy,
    output logic                drop_pulse,
    output logic [CNT_W-1:0]    drop_count
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_xfer = 2'd2;
    localparam logic [1:0] c_st_drop = 2'd3;

    logic [1:0]          r_state;
    logic [DST_SIZE-1:0] r_req_dst;
    logic [LEN_W-1:0]    r_rem;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]    r_drop_count;
    logic                r_drop_pulse;

    logic w_active;
    logic w_hdr_acc;
    logic w_last;
    logic w_timeout;
    logic w_drop_event;

    always_comb begin
        w_active     = (r_state == c_st_req) || (r_state == c_st_xfer);
        hdr_ready    = (r_state == c_st_idle);
        pl_ready     = (w_active && grant) || (r_state == c_st_drop);
        xfer_valid   = w_active && grant && pl_valid;
        w_hdr_acc    = hdr_valid && (r_state == c_st_idle);
        w_last       = (r_rem == LEN_W'(1));
        w_timeout    = (TIMEOUT != 0) && !grant && (r_wait_cnt == c_wait_last);
        // A zero-length header counts as a drop without ever leaving IDLE.
        w_drop_event = (w_hdr_acc && (hdr_len == '0)) ||
                       ((r_state == c_st_drop) && pl_valid && w_last);
    end

    assign busy       = (r_state != c_st_idle);
    assign req_dst    = r_req_dst;
    assign drop_pulse = r_drop_pulse;
    assign drop_count = r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_req_dst    <= '0;
            r_rem        <= '0;
            r_wait_cnt   <= '0;
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop_event;
            if (w_drop_event && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end

            case (r_state)
                c_st_idle: begin
                    if (w_hdr_acc) begin
                        r_rem      <= hdr_len;
                        r_wait_cnt <= '0;
                        if (hdr_len == '0) begin
                            r_state <= c_st_idle;
                        end else if (hdr_dst == '0) begin
                            r_state <= c_st_drop;
                        end else begin
                            r_state   <= c_st_req;
                            r_req_dst <= hdr_dst;
                        end
                    end
                end
                c_st_req: begin
                    if (grant) begin
                        r_wait_cnt <= '0;
                        if (pl_valid) begin
                            r_rem <= r_rem - LEN_W'(1);
                            if (w_last) begin
                                r_state   <= c_st_idle;
                                r_req_dst <= '0;
                            end else begin
                                r_state <= c_st_xfer;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state    <= c_st_drop;
                        r_req_dst  <= '0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                c_st_xfer: begin
                    // Grant low simply stalls here; no timeout once data has moved.
                    if (xfer_valid) begin
                        r_rem <= r_rem - LEN_W'(1);
                        if (w_last) begin
                            r_state   <= c_st_idle;
                            r_req_dst <= '0;
                        end
                    end
                end
                c_st_drop: begin
                    if (pl_valid) begin
                        r_rem <= r_rem - LEN_W'(1);
                        if (w_last) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_req_dst <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
